// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   arb_state_e : arbiter FSM states
//   MT_*        : memory access size encodings (matches cpu/dma/mem type fields)
//   REQ_*       : requester ids, also the encoding of the owner/last-grant registers
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } arb_state_e;

    localparam logic [1:0] MT_BYTE = 2'b00;
    localparam logic [1:0] MT_HALF = 2'b01;
    localparam logic [1:0] MT_WORD = 2'b10;
    localparam logic [1:0] MT_RSVD = 2'b11;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

endpackage

// File: rtl/dmem_align_chk.sv
// Alignment checker for a single memory request.
//   type_i       : access size (MT_BYTE/MT_HALF/MT_WORD/MT_RSVD)
//   addr_lsb_i   : byte address bits [1:0]
//   misaligned_o : 1 for a misaligned half/word or the reserved size
module dmem_align_chk
    import dmem_arb_pkg::*;
(
    input  logic [1:0] type_i,
    input  logic [1:0] addr_lsb_i,
    output logic       misaligned_o
);

    always_comb begin
        unique case (type_i)
            MT_BYTE: misaligned_o = 1'b0;
            MT_HALF: misaligned_o = addr_lsb_i[0];
            MT_WORD: misaligned_o = |addr_lsb_i;
            default: misaligned_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the CPU memory stage and the DMA/loader port.
// One requester is granted at a time; its request is latched and held on mem_* for MEM_LAT
// cycles, then a one-cycle done pulse returns the registered read data.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   cpu_* / dma_*      : request fields in, done/err/rdata out; cpu_stall_o holds the pipeline
//   mem_*              : memory port, all zero outside the access phase
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration (default: CPU priority).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_LAT    = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic [DATA_WIDTH-1:0] cpu_addr_i,
    input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
    input  logic [1:0]            cpu_type_i,
    input  logic                  cpu_sign_i,
    output logic                  cpu_stall_o,
    output logic                  cpu_done_o,
    output logic                  cpu_err_o,
    output logic [DATA_WIDTH-1:0] cpu_rdata_o,
    input  logic                  dma_req_i,
    input  logic                  dma_we_i,
    input  logic [DATA_WIDTH-1:0] dma_addr_i,
    input  logic [DATA_WIDTH-1:0] dma_wdata_i,
    input  logic [1:0]            dma_type_i,
    input  logic                  dma_sign_i,
    output logic                  dma_done_o,
    output logic                  dma_err_o,
    output logic [DATA_WIDTH-1:0] dma_rdata_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [1:0]            mem_type_o,
    output logic                  mem_sign_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int unsigned CntW = 3;
    localparam logic [CntW-1:0] CntInit = CntW'(MEM_LAT - 1);

    arb_state_e state_q, state_d;

    logic                  owner_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            type_q;
    logic                  sign_q;
    logic                  err_q;
    logic [CntW-1:0]       cnt_q;

    logic                  any_req;
    logic                  sel_dma;
    logic                  req_we;
    logic [DATA_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [1:0]            req_type;
    logic                  req_sign;
    logic                  misaligned;
    logic                  last_cycle;

    assign any_req    = cpu_req_i | dma_req_i;
    assign last_cycle = (cnt_q == '0);

`ifdef DMEM_ARB_RR_EN
    // Last-grant pointer; resets to DMA so the CPU wins the first contested grant.
    logic last_q;

    assign sel_dma = (cpu_req_i & dma_req_i) ? (last_q == REQ_CPU) : dma_req_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= REQ_DMA;
        end else if (state_q == StIdle && any_req) begin
            last_q <= sel_dma;
        end
    end
`else
    assign sel_dma = dma_req_i & ~cpu_req_i;
`endif

    assign req_we    = sel_dma ? dma_we_i    : cpu_we_i;
    assign req_addr  = sel_dma ? dma_addr_i  : cpu_addr_i;
    assign req_wdata = sel_dma ? dma_wdata_i : cpu_wdata_i;
    assign req_type  = sel_dma ? dma_type_i  : cpu_type_i;
    assign req_sign  = sel_dma ? dma_sign_i  : cpu_sign_i;

    dmem_align_chk u_align_chk (
        .type_i       (req_type),
        .addr_lsb_i   (req_addr[1:0]),
        .misaligned_o (misaligned)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (any_req) state_d = misaligned ? StDone : StAccess;
            StAccess: if (last_cycle) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner_q <= REQ_CPU;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            type_q  <= MT_BYTE;
            sign_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        owner_q <= sel_dma;
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        type_q  <= req_type;
                        sign_q  <= req_sign;
                        err_q   <= misaligned;
                        rdata_q <= '0;
                        cnt_q   <= CntInit;
                    end
                end
                StAccess: begin
                    if (last_cycle) begin
                        rdata_q <= we_q ? '0 : mem_rdata_i;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_type_o  = MT_BYTE;
        mem_sign_o  = 1'b0;
        cpu_done_o  = 1'b0;
        cpu_err_o   = 1'b0;
        cpu_rdata_o = '0;
        dma_done_o  = 1'b0;
        dma_err_o   = 1'b0;
        dma_rdata_o = '0;
        unique case (state_q)
            StAccess: begin
                mem_addr_o  = addr_q;
                mem_wdata_o = wdata_q;
                mem_type_o  = type_q;
                mem_sign_o  = sign_q;
                // Suppress the write if reset lands on the final access cycle.
                mem_we_o    = we_q & last_cycle & ~rst_i;
            end
            StDone: begin
                if (owner_q == REQ_DMA) begin
                    dma_done_o  = 1'b1;
                    dma_err_o   = err_q;
                    dma_rdata_o = rdata_q;
                end else begin
                    cpu_done_o  = 1'b1;
                    cpu_err_o   = err_q;
                    cpu_rdata_o = rdata_q;
                end
            end
            default: ;
        endcase
    end

    assign cpu_stall_o = cpu_req_i & ~cpu_done_o;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: instance a (MEM_LAT=1) is checked every cycle against a
// transaction-level model; instance b (MEM_LAT=4) covers long latency and reset mid-access.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int LAT  = 1;
    localparam int LAT4 = 4;

    logic clk, rst;
    logic cpu_req, cpu_we, cpu_sign, dma_req, dma_we, dma_sign;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [1:0] cpu_type, dma_type;

    logic a_cpu_stall, a_cpu_done, a_cpu_err, a_dma_done, a_dma_err, a_mem_we, a_mem_sign;
    logic [31:0] a_cpu_rdata, a_dma_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [1:0] a_mem_type;
    logic b_cpu_stall, b_cpu_done, b_cpu_err, b_dma_done, b_dma_err, b_mem_we, b_mem_sign;
    logic [31:0] b_cpu_rdata, b_dma_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [1:0] b_mem_type;

    logic [31:0] mem_word [64];
    assign a_mem_rdata = mem_word[a_mem_addr[7:2]];
    assign b_mem_rdata = mem_word[b_mem_addr[7:2]];

    dmem_arbiter #(.DATA_WIDTH(32), .MEM_LAT(LAT)) u_dut_a (
        .clk_i(clk), .rst_i(rst),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_type_i(cpu_type), .cpu_sign_i(cpu_sign), .cpu_stall_o(a_cpu_stall),
        .cpu_done_o(a_cpu_done), .cpu_err_o(a_cpu_err), .cpu_rdata_o(a_cpu_rdata),
        .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
        .dma_type_i(dma_type), .dma_sign_i(dma_sign), .dma_done_o(a_dma_done),
        .dma_err_o(a_dma_err), .dma_rdata_o(a_dma_rdata),
        .mem_we_o(a_mem_we), .mem_addr_o(a_mem_addr), .mem_wdata_o(a_mem_wdata),
        .mem_type_o(a_mem_type), .mem_sign_o(a_mem_sign), .mem_rdata_i(a_mem_rdata)
    );

    dmem_arbiter #(.DATA_WIDTH(32), .MEM_LAT(LAT4)) u_dut_b (
        .clk_i(clk), .rst_i(rst),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_type_i(cpu_type), .cpu_sign_i(cpu_sign), .cpu_stall_o(b_cpu_stall),
        .cpu_done_o(b_cpu_done), .cpu_err_o(b_cpu_err), .cpu_rdata_o(b_cpu_rdata),
        .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
        .dma_type_i(dma_type), .dma_sign_i(dma_sign), .dma_done_o(b_dma_done),
        .dma_err_o(b_dma_err), .dma_rdata_o(b_dma_rdata),
        .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata),
        .mem_type_o(b_mem_type), .mem_sign_o(b_mem_sign), .mem_rdata_i(b_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  typ;
        logic        sign;
    } txn_t;

    // Requester side
    txn_t pend [2];
    bit   has [2];
    int   ready_at [2];
    bit   rand_en;
    // Arbiter model: one transaction in flight, scheduled in absolute cycles
    bit   act;
    int   own;
    txn_t cur;
    bit   cur_err;
    int   grant_cyc, done_cyc;
`ifdef DMEM_ARB_RR_EN
    bit   last_dma;
`endif
    int   cyc;
    int unsigned n_checks, n_pass;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    endtask

    function automatic bit bad_align(input txn_t t);
        if (t.typ == 2'd3) return 1'b1;
        if (t.typ == 2'd2) return (t.addr % 4) != 0;
        if (t.typ == 2'd1) return (t.addr % 2) != 0;
        return 1'b0;
    endfunction

    task automatic post(input int r, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] typ, input bit sign);
        pend[r] = '{we: we, addr: addr, wdata: wdata, typ: typ, sign: sign};
        has[r] = 1'b1;
        ready_at[r] = cyc;
    endtask

    task automatic gen_random();
        for (int r = 0; r < 2; r++) begin
            if (!has[r] && cyc >= ready_at[r] && $urandom_range(2) == 0) begin
                txn_t t;
                t.we    = 1'($urandom_range(1));
                t.typ   = ($urandom_range(9) == 0) ? 2'd3 : 2'($urandom_range(2));
                t.addr  = $urandom;
                t.wdata = $urandom;
                t.sign  = 1'($urandom_range(1));
                if ($urandom_range(3) != 0) begin
                    if (t.typ == 2'd2) t.addr[1:0] = 2'b00;
                    if (t.typ == 2'd1) t.addr[0] = 1'b0;
                end
                pend[r] = t;
                has[r] = 1'b1;
                ready_at[r] = cyc;
            end
        end
    endtask

    task automatic drive_inputs();
        bit r0, r1;
        r0 = has[0] && cyc >= ready_at[0];
        r1 = has[1] && cyc >= ready_at[1];
        cpu_req = r0; cpu_we = r0 & pend[0].we; cpu_sign = r0 & pend[0].sign;
        cpu_addr = r0 ? pend[0].addr : 32'd0; cpu_wdata = r0 ? pend[0].wdata : 32'd0;
        cpu_type = r0 ? pend[0].typ : 2'd0;
        dma_req = r1; dma_we = r1 & pend[1].we; dma_sign = r1 & pend[1].sign;
        dma_addr = r1 ? pend[1].addr : 32'd0; dma_wdata = r1 ? pend[1].wdata : 32'd0;
        dma_type = r1 ? pend[1].typ : 2'd0;
    endtask

    task automatic check_cycle();
        bit in_acc, last, dn, dc, dd;
        logic [31:0] exp_rd;
        in_acc = act && !cur_err && (cyc > grant_cyc) && (cyc <= grant_cyc + LAT);
        last   = in_acc && (cyc == grant_cyc + LAT);
        dn     = act && (cyc == done_cyc);
        dc     = dn && (own == 0);
        dd     = dn && (own == 1);
        exp_rd = (dn && !cur_err && !cur.we) ? mem_word[cur.addr[7:2]] : 32'd0;
        check_eq("mem_we", 32'(a_mem_we), 32'(last && cur.we));
        check_eq("mem_addr", a_mem_addr, in_acc ? cur.addr : 32'd0);
        check_eq("mem_wdata", a_mem_wdata, in_acc ? cur.wdata : 32'd0);
        check_eq("mem_type", 32'(a_mem_type), in_acc ? 32'(cur.typ) : 32'd0);
        check_eq("mem_sign", 32'(a_mem_sign), 32'(in_acc && cur.sign));
        check_eq("cpu_done", 32'(a_cpu_done), 32'(dc));
        check_eq("cpu_err", 32'(a_cpu_err), 32'(dc && cur_err));
        check_eq("cpu_rdata", a_cpu_rdata, dc ? exp_rd : 32'd0);
        check_eq("dma_done", 32'(a_dma_done), 32'(dd));
        check_eq("dma_err", 32'(a_dma_err), 32'(dd && cur_err));
        check_eq("dma_rdata", a_dma_rdata, dd ? exp_rd : 32'd0);
        check_eq("cpu_stall", 32'(a_cpu_stall), 32'(cpu_req && !dc));
    endtask

    task automatic update_model();
        int w;
        if (act) begin
            if (cyc == done_cyc) begin
                act = 1'b0;
                has[own] = 1'b0;
                ready_at[own] = cyc + 2;
            end
        end else if (cpu_req || dma_req) begin
`ifdef DMEM_ARB_RR_EN
            if (cpu_req && dma_req) w = last_dma ? 0 : 1;
            else w = dma_req ? 1 : 0;
            last_dma = (w == 1);
`else
            w = cpu_req ? 0 : 1;
`endif
            own = w;
            cur = pend[w];
            cur_err = bad_align(cur);
            grant_cyc = cyc;
            done_cyc = cyc + (cur_err ? 1 : LAT + 1);
            act = 1'b1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rand_en) gen_random();
        drive_inputs();
        #1;
        check_cycle();
        update_model();
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        has[0] = 1'b0; has[1] = 1'b0;
        drive_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_zero_a", 32'(|{a_cpu_done, a_cpu_err, a_cpu_rdata, a_dma_done, a_dma_err,
                 a_dma_rdata, a_mem_we, a_mem_addr, a_mem_wdata, a_mem_type, a_mem_sign,
                 a_cpu_stall}), 32'd0);
        check_eq("rst_zero_b", 32'(|{b_cpu_done, b_cpu_err, b_cpu_rdata, b_dma_done, b_dma_err,
                 b_dma_rdata, b_mem_we, b_mem_addr, b_mem_wdata, b_mem_type, b_mem_sign,
                 b_cpu_stall}), 32'd0);
        rst = 1'b0;
        cyc += 2;
        act = 1'b0;
        ready_at[0] = cyc; ready_at[1] = cyc;
`ifdef DMEM_ARB_RR_EN
        last_dma = 1'b1;
`endif
    endtask

    task automatic set_cpu(input bit req, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata);
        cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        cpu_type = MT_WORD; cpu_sign = 1'b0; dma_req = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_pass = 0; cyc = 0; rand_en = 1'b0;
        for (int i = 0; i < 64; i++) mem_word[i] = $urandom;
        mem_word[4]  = 32'hFFFF_FF80;
        mem_word[17] = 32'hCAFE_F00D;
        do_reset();

        post(0, 1'b1, 32'h10, 32'hDEAD_BEEF, MT_WORD, 1'b0); run(4);   // word write
        post(0, 1'b0, 32'h13, 32'h0, MT_BYTE, 1'b1); run(4);           // signed byte load
        post(0, 1'b0, 32'h20, 32'h0, MT_WORD, 1'b0);                   // simultaneous pair
        post(1, 1'b0, 32'h24, 32'h0, MT_WORD, 1'b0); run(8);
        post(0, 1'b1, 32'h28, 32'h1111_2222, MT_HALF, 1'b0); run(4);   // CPU alone, then pair
        post(0, 1'b0, 32'h2C, 32'h0, MT_WORD, 1'b0);
        post(1, 1'b1, 32'h34, 32'h3333_4444, MT_WORD, 1'b0); run(8);
        post(1, 1'b0, 32'h21, 32'h0, MT_HALF, 1'b0); run(3);           // misaligned DMA half
        post(0, 1'b1, 32'h30, 32'h5555_6666, 2'b11, 1'b0); run(3);     // reserved type

        rand_en = 1'b1; run(800);
        rand_en = 1'b0; run(6);

        // MEM_LAT=4: reset in the 2nd access cycle of a write
        do_reset();
        @(negedge clk); set_cpu(1'b1, 1'b1, 32'h40, 32'h1234_5678); #1;
        check_eq("b_stall_req", 32'(b_cpu_stall), 32'd1);
        @(negedge clk); #1;
        check_eq("b_acc1_addr", b_mem_addr, 32'h40);
        check_eq("b_acc1_we", 32'(b_mem_we), 32'd0);
        @(negedge clk); rst = 1'b1; #1;
        check_eq("b_acc2_addr", b_mem_addr, 32'h40);
        check_eq("b_rst_we", 32'(b_mem_we), 32'd0);
        @(negedge clk); rst = 1'b0; set_cpu(1'b0, 1'b0, 32'h0, 32'h0); #1;
        check_eq("b_post_rst", 32'(|{b_cpu_done, b_cpu_err, b_cpu_rdata, b_dma_done,
                 b_mem_we, b_mem_addr, b_mem_wdata, b_mem_type, b_mem_sign}), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            check_eq("b_no_we", 32'(b_mem_we), 32'd0);
            check_eq("b_no_done", 32'(b_cpu_done), 32'd0);
        end

        // MEM_LAT=4: word read, done at t+5
        @(negedge clk); set_cpu(1'b1, 1'b0, 32'h44, 32'h0); #1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk); #1;
            if (k <= 4) begin
                check_eq("b_rd_addr", b_mem_addr, 32'h44);
                check_eq("b_rd_done_early", 32'(b_cpu_done), 32'd0);
                check_eq("b_rd_stall", 32'(b_cpu_stall), 32'd1);
            end else begin
                check_eq("b_rd_done", 32'(b_cpu_done), 32'd1);
                check_eq("b_rd_data", b_cpu_rdata, 32'hCAFE_F00D);
                check_eq("b_rd_stall_end", 32'(b_cpu_stall), 32'd0);
                check_eq("b_rd_mem_idle", b_mem_addr, 32'd0);
            end
        end
        @(negedge clk); set_cpu(1'b0, 1'b0, 32'h0, 32'h0); #1;
        check_eq("b_done_once", 32'(b_cpu_done), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
